// File: rtl/pc_update.sv
// PC owner for the single-cycle CPU: fetch handshake, execute slot, next-PC.
// Ports: clk/rst, pc_src/imm/rs1_data/exec_done in; ifu req/rsp handshake; pc, pc_plus4, retire, misalign out.
module pc_update #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            exec_done,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_req_ready,
  input  logic            ifu_rsp_valid,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            retire,
  output logic            misalign
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    EXEC,
    TRAP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            retire_q, retire_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jal_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  assign seq_pc   = pc_q + XLEN'(4);
  assign jal_pc   = pc_q + imm;
  assign jalr_sum = rs1_data + imm;

  // Reserved select 11 falls back to sequential flow.
  always_comb begin
    target = seq_pc;
    unique case (pc_src)
      2'b01:   target = jal_pc;
      2'b10:   target = {jalr_sum[XLEN-1:1], 1'b0};
      default: target = seq_pc;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retire_d   = 1'b0;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ifu_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (ifu_rsp_valid) state_d = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          if (target[1:0] == 2'b00) begin
            pc_d     = target;
            retire_d = 1'b1;
            state_d  = REQ;
          end else begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      retire_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retire_q   <= retire_d;
      misalign_q <= misalign_d;
    end
  end

  assign ifu_req_valid = (state_q == REQ);
  assign ifu_req_addr  = pc_q;
  assign inst_valid    = (state_q == EXEC);
  assign pc            = pc_q;
  assign pc_plus4      = seq_pc;
  assign retire        = retire_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_pc_update.sv
// Directed + randomized bench for pc_update.
// Transaction-level reference model predicts PC, handshakes, retire, misalign.
module tb_pc_update;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        exec_done = 1'b0;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic        misalign;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] exp_pc;

  pc_update #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .pc_src(pc_src),
    .imm(imm),
    .rs1_data(rs1_data),
    .exec_done(exec_done),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid),
    .inst_valid(inst_valid),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .retire(retire),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, using wide arithmetic then truncation.
  function automatic logic [31:0] ref_target(input logic [1:0] src, input logic [31:0] p,
                                             input logic [31:0] i, input logic [31:0] r);
    longint t;
    case (src)
      2'd1: t = longint'(p) + longint'(i);
      2'd2: begin
        t = longint'(r) + longint'(i);
        t = t - (t % 2);
      end
      default: t = longint'(p) + 4;
    endcase
    return t[31:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    exec_done = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    tick();
    exp_pc = RST_PC;
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_req_valid", 32'(ifu_req_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_misalign", 32'(misalign), 0);
    rst = 1'b0;
    chk("idle_req_valid", 32'(ifu_req_valid), 0);
    tick();
  endtask

  // Entered in the first REQ cycle; leaves in the first EXEC cycle.
  task automatic fetch(input int rdy_dly, input int rsp_dly);
    for (int i = 0; i < rdy_dly; i++) begin
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      chk("stall_req_valid", 32'(ifu_req_valid), 1);
      chk("stall_req_addr", ifu_req_addr, exp_pc);
      chk("stall_inst_valid", 32'(inst_valid), 0);
      tick();
    end
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    chk("req_valid", 32'(ifu_req_valid), 1);
    chk("req_addr", ifu_req_addr, exp_pc);
    chk("req_pc", pc, exp_pc);
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      chk("wait_req_valid", 32'(ifu_req_valid), 0);
      chk("wait_inst_valid", 32'(inst_valid), 0);
      chk("wait_retire", 32'(retire), 0);
      tick();
    end
    exec_done = 1'b0;
    ifu_rsp_valid = 1'b1;
    chk("rsp_req_valid", 32'(ifu_req_valid), 0);
    chk("rsp_inst_valid", 32'(inst_valid), 0);
    tick();
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic execute(input int dly, input logic [1:0] src,
                         input logic [31:0] im, input logic [31:0] r);
    logic [31:0] tgt;
    for (int i = 0; i < dly; i++) begin
      exec_done = 1'b0;
      pc_src = 2'($urandom);
      imm = $urandom;
      rs1_data = $urandom;
      chk("hold_inst_valid", 32'(inst_valid), 1);
      chk("hold_pc", pc, exp_pc);
      chk("hold_retire", 32'(retire), 0);
      tick();
    end
    exec_done = 1'b1;
    pc_src = src;
    imm = im;
    rs1_data = r;
    chk("exec_inst_valid", 32'(inst_valid), 1);
    chk("exec_retire", 32'(retire), 0);
    chk("exec_pc", pc, exp_pc);
    tgt = ref_target(src, exp_pc, im, r);
    tick();
    exec_done = 1'b0;
    if (tgt % 4 == 0) begin
      exp_pc = tgt;
      chk("ret_retire", 32'(retire), 1);
      chk("ret_pc", pc, exp_pc);
      chk("ret_pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("ret_req_valid", 32'(ifu_req_valid), 1);
      chk("ret_misalign", 32'(misalign), 0);
    end else begin
      chk("trap_misalign", 32'(misalign), 1);
      chk("trap_retire", 32'(retire), 0);
      chk("trap_pc", pc, exp_pc);
      chk("trap_req_valid", 32'(ifu_req_valid), 0);
      chk("trap_inst_valid", 32'(inst_valid), 0);
    end
  endtask

  task automatic instr(input int rdy, input int rsp, input int dly,
                       input logic [1:0] src, input logic [31:0] im, input logic [31:0] r);
    fetch(rdy, rsp);
    execute(dly, src, im, r);
  endtask

  initial begin
    logic [1:0]  s;
    logic [31:0] im;
    logic [31:0] r;

    do_reset();

    // Sequential flow, zero-wait IFU.
    chk("seq0_pc", pc, 32'h8000_0000);
    instr(0, 0, 0, 2'b00, 0, 0);
    chk("seq1_pc", pc, 32'h8000_0004);
    instr(0, 0, 0, 2'b00, 0, 0);
    chk("seq2_pc", pc, 32'h8000_0008);
    instr(0, 0, 0, 2'b00, 0, 0);
    instr(0, 0, 0, 2'b00, 0, 0);
    chk("seq4_pc", pc, 32'h8000_0010);

    // Branch backwards and jalr with bit0 cleared.
    instr(0, 0, 0, 2'b01, 32'hFFFF_FFF0, 0);
    chk("jal_back_pc", pc, 32'h8000_0000);
    instr(0, 0, 0, 2'b10, 32'd3, 32'h8000_0101);
    chk("jalr_pc", pc, 32'h8000_0104);

    // Stalled IFU and delayed execute.
    instr(4, 2, 2, 2'b00, 0, 0);

    // Randomized aligned instruction stream.
    for (int n = 0; n < 12; n++) begin
      s = 2'($urandom_range(0, 3));
      im = $urandom & 32'hFFFF_FFFC;
      r = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), s, im, r);
    end

    // Wrap-around at top of address space; 11 behaves as 00.
    instr(0, 0, 0, 2'b10, 32'h0000_000C, 32'hFFFF_FFF0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc_plus4", pc_plus4, 32'h0000_0000);
    instr(0, 0, 0, 2'b00, 0, 0);
    chk("wrap00_pc", pc, 32'h0000_0000);
    instr(0, 0, 0, 2'b10, 32'h0000_000C, 32'hFFFF_FFF0);
    instr(1, 1, 1, 2'b11, $urandom, $urandom);
    chk("wrap11_pc", pc, 32'h0000_0000);

    // Misaligned target traps until reset.
    instr(0, 0, 0, 2'b01, 32'd2, 0);
    for (int i = 0; i < 4; i++) begin
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      exec_done = 1'($urandom_range(0, 1));
      tick();
      chk("hold_trap_req", 32'(ifu_req_valid), 0);
      chk("hold_trap_inst", 32'(inst_valid), 0);
      chk("hold_trap_mis", 32'(misalign), 1);
      chk("hold_trap_ret", 32'(retire), 0);
      chk("hold_trap_pc", pc, exp_pc);
      chk("hold_trap_pc4", pc_plus4, exp_pc + 32'd4);
    end
    do_reset();
    chk("post_trap_mis", 32'(misalign), 0);
    chk("post_trap_pc", pc, RST_PC);

    // Reset while waiting; stray response afterwards is ignored.
    instr(0, 0, 0, 2'b00, 0, 0);
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    exp_pc = RST_PC;
    chk("wrst_pc", pc, RST_PC);
    chk("wrst_inst", 32'(inst_valid), 0);
    chk("wrst_req", 32'(ifu_req_valid), 0);
    rst = 1'b0;
    ifu_rsp_valid = 1'b1;
    tick();
    chk("stray_req", 32'(ifu_req_valid), 1);
    chk("stray_addr", ifu_req_addr, RST_PC);
    chk("stray_inst", 32'(inst_valid), 0);
    tick();
    chk("stray2_req", 32'(ifu_req_valid), 1);
    chk("stray2_inst", 32'(inst_valid), 0);
    ifu_rsp_valid = 1'b0;
    instr(0, 1, 0, 2'b00, 0, 0);
    chk("restart_pc", pc, 32'h8000_0004);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
